// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: serialiser states, frame
// constants, the TX register address used by the IO decode and a parity helper.
package uart_pkg;

    localparam int             DATA_BITS       = 8;
    localparam logic           UART_IDLE_LEVEL = 1'b1;
    localparam logic [15:0]    UART_TX_ADDR    = 16'hFF00;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_t;

    // Serialiser register file; kept as one struct so the FSM state is
    // visible as a single named signal.
    typedef struct packed {
        uart_state_t            state;
        logic [2:0]             bit_cnt;
        logic [DATA_BITS-1:0]   shift;
    } uart_tx_regs_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count and a sticky overflow flag.
// Handshake: push is honoured only while full is low (a push while full is
// dropped and sets overflow); pop is honoured only while empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             ovf_clr
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_n;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_n = count;
        case ({do_push, do_pop})
            2'b10:   count_n = count + (AW+1)'(1);
            2'b01:   count_n = count - (AW+1)'(1);
            default: count_n = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            full  <= (count_n == (AW+1)'(DEPTH));
            empty <= (count_n == '0);
            // A dropped write wins over a clear in the same cycle.
            if (push && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: CPU bytes queue in a sync_fifo and are serialised 8N1,
// LSB first. Define UART_TX_PARITY_EN to add an even-parity bit before STOP.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 4,
    parameter  int FIFO_DEPTH   = 8,
    localparam int FIFO_AW      = $clog2(FIFO_DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       tx
);

    localparam int             BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

    uart_tx_regs_t        r;
    uart_tx_regs_t        r_n;
    logic [BW-1:0]        baud_cnt;
    logic [BW-1:0]        baud_n;
    logic                 baud_last;
    logic                 pop;
    logic [DATA_BITS-1:0] pop_data;
`ifdef UART_TX_PARITY_EN
    logic                 par;
    logic                 par_n;
`endif

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign busy      = (r.state != IDLE) || !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r        <= '{state: IDLE, bit_cnt: '0, shift: '0};
            baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            r        <= r_n;
            baud_cnt <= baud_n;
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    always_comb begin
        r_n    = r;
        baud_n = baud_cnt + BW'(1);
        pop    = 1'b0;
        tx     = UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
        par_n  = par;
`endif
        case (r.state)
            IDLE: begin
                baud_n = '0;
                if (!empty) begin
                    pop         = 1'b1;
                    r_n.shift   = pop_data;
                    r_n.bit_cnt = '0;
                    r_n.state   = START;
`ifdef UART_TX_PARITY_EN
                    par_n       = even_parity(pop_data);
`endif
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_last) begin
                    baud_n      = '0;
                    r_n.bit_cnt = '0;
                    r_n.state   = DATA;
                end
            end
            DATA: begin
                tx = r.shift[0];
                if (baud_last) begin
                    baud_n    = '0;
                    r_n.shift = r.shift >> 1;
                    if (r.bit_cnt == BIT_LAST) begin
                        r_n.bit_cnt = '0;
`ifdef UART_TX_PARITY_EN
                        r_n.state   = PARITY;
`else
                        r_n.state   = STOP;
`endif
                    end else begin
                        r_n.bit_cnt = r.bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = par;
                if (baud_last) begin
                    baud_n    = '0;
                    r_n.state = STOP;
                end
            end
`endif
            STOP: begin
                tx = UART_IDLE_LEVEL;
                if (baud_last) begin
                    baud_n = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!empty) begin
                        pop         = 1'b1;
                        r_n.shift   = pop_data;
                        r_n.bit_cnt = '0;
                        r_n.state   = START;
`ifdef UART_TX_PARITY_EN
                        par_n       = even_parity(pop_data);
`endif
                    end else begin
                        r_n.state = IDLE;
                    end
                end
            end
            default: begin
                baud_n    = '0;
                r_n.state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=8); a line
// monitor decodes frames from tx and a byte scoreboard checks them in order.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [10:0] FRAME_A5 = 11'b10101001010;
`else
    localparam int NBITS = 10;
    localparam logic [10:0] FRAME_A5 = 11'b01101001010;
`endif
    localparam int FRAME_CYC = NBITS * 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;
    logic       tx;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;

    logic [7:0]  exp_q[$];
    logic [10:0] frame_q[$];
    int          start_q[$];

    uart_tx_fifo #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .tx       (tx)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line monitor: samples each bit at its centre; frames cut by reset are discarded.
    initial begin : monitor
        logic [10:0] fr;
        bit          bad;
        int          t0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && tx === 1'b0) begin
                t0  = cyc_cnt;
                fr  = '0;
                bad = 1'b0;
                cyc(2);
                fr[0] = tx;
                if (rst) bad = 1'b1;
                for (int b = 1; b < NBITS; b++) begin
                    cyc(4);
                    fr[b] = tx;
                    if (rst) bad = 1'b1;
                end
                if (!bad) begin
                    frame_q.push_back(fr);
                    start_q.push_back(t0);
                end
            end
        end
    end

    // Scoreboard: wait (bounded) for every expected byte, then compare in order.
    task automatic drain(input int bound);
        int          n;
        logic [10:0] fr;
        logic [7:0]  e;
        n = 0;
        while (frame_q.size() < exp_q.size() && n < bound) begin
            cyc(1);
            n++;
        end
        check("frame_count", frame_q.size(), exp_q.size());
        while (exp_q.size() > 0 && frame_q.size() > 0) begin
            fr = frame_q.pop_front();
            e  = exp_q.pop_front();
            check("rx_byte", fr[8:1], e);
            check("rx_start", fr[0], 1'b0);
            check("rx_stop", fr[NBITS-1], 1'b1);
        end
        exp_q.delete();
    endtask

    task automatic clear_queues();
        exp_q.delete();
        frame_q.delete();
        start_q.delete();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          n;
        int          idx;
        bit          saw_full;
        logic [10:0] fr;

        // Reset held five cycles.
        cyc(5);
        rst = 1'b0;
        cyc(1);
        check("rst_tx", tx, 1'b1);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);

        // Single byte 0xA5.
        clear_queues();
        wr_en = 1'b1; wr_data = 8'hA5;
        cyc(1);
        wr_en = 1'b0;
        check("single_tx_at_write", tx, 1'b1);
        check("single_busy_rise", busy, 1'b1);
        check("single_empty_fall", empty, 1'b0);
        cyc(1);
        check("single_tx_fall", tx, 1'b0);
        n = 0;
        while (busy && n < 200) begin
            cyc(1);
            n++;
        end
        check("single_busy_len", n, FRAME_CYC);
        check("single_frame_cnt", frame_q.size(), 1);
        if (frame_q.size() > 0) begin
            fr = frame_q.pop_front();
            check("single_frame_bits", fr, FRAME_A5);
        end

        // Back-to-back 0x55, 0x0F.
        cyc(5);
        clear_queues();
        wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
        cyc(1);
        wr_data = 8'h0F; exp_q.push_back(8'h0F);
        cyc(1);
        wr_en = 1'b0;
        check("b2b_tx_fall", tx, 1'b0);
        n = 0;
        while (start_q.size() < 2 && n < 200) begin
            cyc(1);
            n++;
        end
        check("b2b_start_cnt", start_q.size(), 2);
        if (start_q.size() >= 2) check("b2b_gap", start_q[1] - start_q[0], FRAME_CYC);
        drain(200);

        // Reset in the middle of a frame with a byte still queued.
        cyc(5);
        clear_queues();
        wr_en = 1'b1; wr_data = 8'h3C;
        cyc(1);
        wr_data = 8'hC3;
        cyc(1);
        wr_en = 1'b0;
        check("midrst_tx_low", tx, 1'b0);
        cyc(1);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_empty", empty, 1'b1);
        check("midrst_busy", busy, 1'b0);
        cyc(5);
        rst = 1'b0;
        cyc(60);
        check("midrst_no_frames", frame_q.size(), 0);
        check("midrst_tx_idle", tx, 1'b1);

        // Fill to full, overflow, set-wins and drop-while-popping.
        clear_queues();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h80 + 8'(i);
            if (i < 9) exp_q.push_back(8'h80 + 8'(i));
            cyc(1);
            if (i == 7) check("ovf_not_full_yet", full, 1'b0);
            if (i == 8) begin
                check("ovf_full", full, 1'b1);
                check("ovf_clear_before", overflow, 1'b0);
            end
        end
        check("ovf_set", overflow, 1'b1);
        check("ovf_full_hold", full, 1'b1);
        wr_data = 8'hDD; ovf_clr = 1'b1;
        cyc(1);
        check("ovf_set_wins", overflow, 1'b1);
        wr_en = 1'b0;
        cyc(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        cyc(29);
        check("ovf_full_before_pop", full, 1'b1);
        wr_en = 1'b1; wr_data = 8'hEE;
        cyc(1);
        wr_en = 1'b0;
        check("ovf_drop_with_pop", overflow, 1'b1);
        check("ovf_full_after_pop", full, 1'b0);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        check("ovf_cleared2", overflow, 1'b0);
        drain(600);
        cyc(60);
        check("ovf_no_extra", frame_q.size(), 0);
        check("ovf_idle_empty", empty, 1'b1);
        check("ovf_idle_busy", busy, 1'b0);

        // Stream 20 bytes, writing whenever there is room.
        clear_queues();
        idx = 0;
        n = 0;
        saw_full = 1'b0;
        while (idx < 20 && n < 2000) begin
            if (full) saw_full = 1'b1;
            if (!full) begin
                wr_en = 1'b1;
                wr_data = 8'(idx);
                exp_q.push_back(8'(idx));
                idx++;
            end else begin
                wr_en = 1'b0;
            end
            cyc(1);
            n++;
        end
        wr_en = 1'b0;
        check("wrap_all_written", idx, 20);
        check("wrap_saw_full", saw_full, 1'b1);
        drain(2000);
        check("wrap_overflow", overflow, 1'b0);

`ifdef UART_TX_PARITY_EN
        // Parity frame for 0x07.
        cyc(10);
        clear_queues();
        wr_en = 1'b1; wr_data = 8'h07;
        cyc(1);
        wr_en = 1'b0;
        cyc(1);
        check("par_tx_fall", tx, 1'b0);
        n = 0;
        while (busy && n < 200) begin
            cyc(1);
            n++;
        end
        check("par_frame_len", n, 44);
        check("par_frame_cnt", frame_q.size(), 1);
        if (frame_q.size() > 0) begin
            fr = frame_q.pop_front();
            check("par_frame_bits", fr, 11'b11000001110);
            check("par_bit", fr[9], 1'b1);
            check("par_stop", fr[10], 1'b1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
